// File: rtl/sift_dir_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | sift_dir_pkg : shared defaults, FSM states and bin-wrap helper    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package sift_dir_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 5;
  localparam int DEF_LANES  = 2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Sum of two bins reduced modulo 2^w; the carry out of bit w-1 is discarded.
  function automatic logic [31:0] bin_wrap(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          w);
    return (a + b) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dir_bin_lut_pipe_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | dir_bin_lut_pipe_if : config, request and result bundle           |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface dir_bin_lut_pipe_if
  import sift_dir_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
);

  logic                      cfg_we;
  logic [ADDR_W-1:0]         cfg_addr;
  logic [DATA_W-1:0]         cfg_data;
  logic                      cfg_ready;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*ADDR_W-1:0]   in_addr;
  logic [DATA_W-1:0]         in_ori;
  logic                      in_rot_en;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_bin;
  logic                      busy;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_addr, in_ori, in_rot_en, out_ready,
    input  cfg_ready, in_ready, out_valid, out_bin, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_addr, in_ori, in_rot_en, out_ready,
    output cfg_ready, in_ready, out_valid, out_bin, busy
  );

endinterface
`default_nettype wire

// File: rtl/dir_lut_ram.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | dir_lut_ram : 1W / LANES-R synchronous read-first table           |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module dir_lut_ram
  import sift_dir_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    re,
  input  logic [LANES*ADDR_W-1:0] raddr,
  output logic [LANES*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads sample the array before this edge's write lands: read-first.
  always_ff @(posedge clk) begin
    if (re) begin
      for (int i = 0; i < LANES; i++) begin
        rdata[i*DATA_W +: DATA_W] <= mem[raddr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dir_bin_lut_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | dir_bin_lut_pipe : writable orientation-bin LUT with rotation     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module dir_bin_lut_pipe
  import sift_dir_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic               clk,
  input  logic               rst,
  dir_bin_lut_pipe_if.slave  bus
);

  localparam logic [ADDR_W-1:0] c_last_addr = '1;

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_init_cnt;
  logic                    r_busy;
  logic                    r_cfg_ready;

  logic                    w_run;
  logic                    w_en;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_we;
  logic [ADDR_W-1:0]       w_waddr;
  logic [DATA_W-1:0]       w_wdata;
  logic [LANES*DATA_W-1:0] w_rdata;
  logic [LANES*DATA_W-1:0] w_bin;

  logic                    r_v0;
  logic [DATA_W-1:0]       r_ori0;
  logic                    r_rot0;
  logic                    r_v1;
  logic [DATA_W-1:0]       r_ori1;
  logic                    r_rot1;
  logic [LANES*DATA_W-1:0] r_tbl1;
  logic                    r_out_valid;
  logic [LANES*DATA_W-1:0] r_out_bin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_busy      <= 1'b1;
      r_cfg_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == c_last_addr) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign w_run      = (r_state == ST_RUN);
  assign w_en       = !r_out_valid || bus.out_ready;
  assign w_in_ready = w_en && w_run;
  assign w_accept   = bus.in_valid && w_in_ready;

  // INIT owns the write port; config writes outside RUN are dropped.
  assign w_we    = w_run ? bus.cfg_we : 1'b1;
  assign w_waddr = w_run ? bus.cfg_addr : r_init_cnt;
  assign w_wdata = w_run ? bus.cfg_data : '0;

  dir_lut_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .re    (w_en),
    .raddr (bus.in_addr),
    .rdata (w_rdata)
  );

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_bin[g*DATA_W +: DATA_W] = r_rot1
        ? DATA_W'(bin_wrap(32'(r_tbl1[g*DATA_W +: DATA_W]), 32'(r_ori1), DATA_W))
        : r_tbl1[g*DATA_W +: DATA_W];
    end
  endgenerate

  // Whole pipe freezes on a stall so the held output beat stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0        <= 1'b0;
      r_ori0      <= '0;
      r_rot0      <= 1'b0;
      r_v1        <= 1'b0;
      r_ori1      <= '0;
      r_rot1      <= 1'b0;
      r_tbl1      <= '0;
      r_out_valid <= 1'b0;
      r_out_bin   <= '0;
    end else if (w_en) begin
      r_v0        <= w_accept;
      r_ori0      <= bus.in_ori;
      r_rot0      <= bus.in_rot_en;
      r_v1        <= r_v0;
      r_ori1      <= r_ori0;
      r_rot1      <= r_rot0;
      r_tbl1      <= w_rdata;
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_out_bin <= w_bin;
      end
    end
  end

  assign bus.cfg_ready = r_cfg_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bin   = r_out_bin;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dir_bin_lut_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_dir_bin_lut_pipe : directed self-checking bench                |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_dir_bin_lut_pipe;

  localparam int AW = 8;
  localparam int DW = 5;
  localparam int LN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dir_bin_lut_pipe_if #(.ADDR_W(AW), .DATA_W(DW), .LANES(LN)) bus ();

  dir_bin_lut_pipe #(.ADDR_W(AW), .DATA_W(DW), .LANES(LN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic init_wait(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 1000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [4:0] d);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
  endtask

  // One request into an empty pipe; checks acceptance and the N+2 latency.
  task automatic do_read(input logic [7:0] a0, input logic [7:0] a1, input logic [4:0] ori,
                         input logic rot, input string tag, output logic [9:0] res);
    @(negedge clk);
    bus.in_addr   = {a1, a0};
    bus.in_ori    = ori;
    bus.in_rot_en = rot;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat0"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_lat2"}, 32'(bus.out_valid), 32'd1);
    res = bus.out_bin;
  endtask

  function automatic logic [9:0] exp_beat(input int k);
    int l0, l1;
    l0 = (k * 3 + 1 + k * 5) % 32;
    l1 = (31 - k + k * 5) % 32;
    return {5'(l1), 5'(l0)};
  endfunction

  initial begin
    int         cyc;
    int         sent;
    int         got;
    logic       fire_in;
    logic       stalled;
    logic [9:0] held_bin;
    logic [9:0] res;

    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_ori    = '0;
    bus.in_rot_en = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      32'(bus.busy),      32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bin",   32'(bus.out_bin),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);

    rst = 1'b0;
    init_wait(cyc);
    check("init_cycles",    32'(cyc),           32'd256);
    check("init_busy",      32'(bus.busy),      32'd0);
    check("init_in_ready",  32'(bus.in_ready),  32'd1);
    check("init_cfg_ready", 32'(bus.cfg_ready), 32'd1);

    do_read(8'h33, 8'h80, 5'h00, 1'b0, "zero", res);
    check("zero_bin", 32'(res), 32'd0);

    cfg_write(8'h00, 5'h0B);
    cfg_write(8'hFF, 5'h16);
    do_read(8'h00, 8'hFF, 5'h00, 1'b0, "wr", res);
    check("wr_bin", 32'(res), 32'({5'h16, 5'h0B}));

    cfg_write(8'h10, 5'h1E);
    do_read(8'h10, 8'h10, 5'h05, 1'b1, "wrap", res);
    check("wrap_bin", 32'(res), 32'({5'h03, 5'h03}));
    do_read(8'h10, 8'h10, 5'h00, 1'b1, "ori0", res);
    check("ori0_bin", 32'(res), 32'({5'h1E, 5'h1E}));
    do_read(8'h10, 8'hFF, 5'h05, 1'b0, "norot", res);
    check("norot_bin", 32'(res), 32'({5'h16, 5'h1E}));

    // Write and read of the same entry on one edge.
    cfg_write(8'h20, 5'h07);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 8'h20;
    bus.cfg_data  = 5'h09;
    bus.in_addr   = {8'h20, 8'h20};
    bus.in_ori    = 5'h00;
    bus.in_rot_en = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_we   = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rf_valid", 32'(bus.out_valid), 32'd1);
    check("rf_old",   32'(bus.out_bin),   32'({5'h07, 5'h07}));
    do_read(8'h20, 8'h00, 5'h00, 1'b0, "rf2", res);
    check("rf_new", 32'(res), 32'({5'h0B, 5'h09}));

    // Backpressure stream: out_ready pattern 1,0,0 repeating.
    for (int k = 0; k < 8; k++) begin
      cfg_write(8'(8'h40 + k), 5'(k * 3 + 1));
      cfg_write(8'(8'h50 + k), 5'(31 - k));
    end
    sent = 0;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held_bin = '0;
    bus.in_rot_en = 1'b1;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = (cyc % 3 == 0);
      bus.in_valid  = (sent < 8);
      bus.in_addr   = {8'(8'h50 + sent), 8'(8'h40 + sent)};
      bus.in_ori    = 5'(sent * 5);
      #1;
      if (stalled) begin
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_bin",   32'(bus.out_bin),   32'(held_bin));
      end
      fire_in = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        check("bp_beat", 32'(bus.out_bin), 32'(exp_beat(got)));
        got++;
      end
      if (bus.out_valid && !bus.out_ready) begin
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      stalled  = bus.out_valid && !bus.out_ready;
      held_bin = bus.out_bin;
      @(posedge clk);
      if (fire_in) sent++;
      cyc++;
    end
    check("bp_count", 32'(got), 32'd8);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Reset with beats in flight.
    cfg_write(8'h60, 5'h11);
    @(negedge clk);
    bus.in_addr   = {8'h60, 8'h60};
    bus.in_ori    = 5'h00;
    bus.in_rot_en = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_valid_pre", 32'(bus.out_valid), 32'd1);
    check("mid_bin_pre",   32'(bus.out_bin),   32'({5'h11, 5'h11}));
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_busy",      32'(bus.busy),      32'd1);
    check("mid_in_ready",  32'(bus.in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 8'h60;
    bus.cfg_data = 5'h1F;
    #1 check("mid_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    @(posedge clk);
    #1 bus.cfg_we = 1'b0;
    @(negedge clk);
    init_wait(cyc);
    check("reinit_cycles", 32'(cyc + 1), 32'd256);
    do_read(8'h60, 8'h20, 5'h00, 1'b0, "post", res);
    check("post_bin", 32'(res), 32'd0);
    do_read(8'h00, 8'hFF, 5'h00, 1'b0, "post2", res);
    check("post2_bin", 32'(res), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dir_bin_lut_pipe.md
# dir_bin_lut_pipe

Parametrised, runtime-writable orientation-bin lookup for the SIFT descriptor stage. It maps a sample address (patch row/column) to a direction bin, optionally rotated by the keypoint's dominant orientation modulo 2^DATA_W. It serves LANES samples per beat through a 2-stage valid/ready pipeline. It replaces fixed per-orientation ROMs: one table is reloaded through a config port, and rotation is applied arithmetically.

## Interface
Parameters:
- ADDR_W, 8, table address width; depth = 2^ADDR_W
- DATA_W, 5, bin width; all bin arithmetic is modulo 2^DATA_W
- LANES, 2, parallel read lanes sharing one handshake

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  ADDR_W  write address
- cfg_data  in  DATA_W  write data
- cfg_ready  out  1  high only in RUN; writes with cfg_ready low are dropped
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_addr  in  LANES*ADDR_W  lane i at [i*ADDR_W +: ADDR_W]
- in_ori  in  DATA_W  orientation offset, common to all lanes
- in_rot_en  in  1  1: add in_ori; 0: raw table value
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_bin  out  LANES*DATA_W  lane-packed bins, same lane order as in_addr
- busy  out  1  high during INIT

## Operation
- FSM states:
  - INIT: entered on reset; an ADDR_W-bit counter writes 0 to entries 0..2^ADDR_W-1, one per cycle. After the final entry the FSM moves to RUN.
  - RUN: the FSM stays here until reset.
- Outputs while in INIT:
  - busy=1, cfg_ready=0, in_ready=0.
  - Pipeline holds no valid data.
- Config writes:
  - In RUN, cfg_we writes cfg_data to entry cfg_addr at the clock edge.
  - Config writes never stall the read pipeline.
- Pipeline enable: en = !out_valid || out_ready.
  - in_ready = en && (state==RUN).
  - Both stages advance only when en=1.
- Stage 1:
  - Captures the table read per lane, plus in_ori, in_rot_en and valid.
  - Read-first semantics: a same-cycle write to the same address returns the OLD value; the new value is visible from the next accepted request.
- Stage 2: out_bin lane i = rot_en ? (tbl + ori) mod 2^DATA_W : tbl. The sum is DATA_W bits and the carry is discarded, giving wrap-around.
- Multiple lanes may read the same address; all of them return the same value.
- Reset mid-operation:
  - In-flight data is discarded and out_valid drops immediately.
  - INIT restarts at address 0, so table contents after reset are all zero.

## Timing
- Values asserted during reset: busy=1, out_valid=0, out_bin=0, in_ready=0, cfg_ready=0.
- INIT lasts exactly 2^ADDR_W cycles after reset deassertion (256 at default). cfg_ready and in_ready may rise in the following cycle.
- Latency: a request accepted at edge N appears on out_valid/out_bin after edge N+2 when unstalled.
- Throughput: one beat per cycle with out_ready held high.
- Backpressure:
  - While out_valid && !out_ready, out_bin and out_valid are held stable and in_ready=0.
  - No beat is lost or duplicated.
- No combinational path from in_valid to out_*. in_ready depends combinationally on out_ready.

## Structure
- Shared package `sift_dir_pkg`: default ADDR_W/DATA_W/LANES, the INIT/RUN state enum, and a bin-wrap helper function.
- Sub-module `dir_lut_ram`: 2^ADDR_W x DATA_W storage with one synchronous write port and LANES synchronous read ports with a read enable, read-first. It maps to distributed RAM.
- The top level holds the FSM, init counter, handshake logic and stage-2 adder.

## Test plan
- Init: release reset -> busy=1 for exactly 256 cycles, then busy=0 and in_ready=1. Reading any address with rot_en=0 returns 0.
- Write/read: write entry 0x00=0x0B and entry 0xFF=0x16, then issue lanes {0x00,0xFF} with rot_en=0 -> out_bin lanes {0x0B,0x16}, 2 cycles after acceptance.
- Rotation wrap: entry 0x10=0x1E, in_ori=0x05, rot_en=1 -> bin 0x03. With in_ori=0x00 -> 0x1E.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,... -> all 8 results arrive in order, none dropped or duplicated, and out_bin is stable while stalled.
- Same-cycle write/read: entry 0x20 holds 0x07. Write 0x09 to 0x20 in the same cycle a read of 0x20 is accepted -> returns 0x07. The next read returns 0x09.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 immediately, busy=1, and table contents are 0 after the new INIT.
